// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and default widths for the PC/fetch front end.
package pc_fetch_unit_pkg;

  localparam int unsigned FETCH_ADDR_W = 32;
  localparam int unsigned FETCH_INST_W = 32;

  // Reset is active-low: rst == RSTN_ENABLE means "in reset".
  localparam logic RSTN_ENABLE = 1'b0;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/pc_fetch_unit_queue.sv
// Synchronous show-ahead FIFO holding {pc, inst} pairs for decode.
// Flush wins over push/pop. The head reads as zero while empty.
module fetch_queue
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned WIDTH = FETCH_ADDR_W + FETCH_INST_W,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] slots [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty && !flush;
  assign do_push   = push && !flush && (!full || do_pop);
  assign head_data = empty ? '0 : slots[rd_ptr];

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage; never read while empty, so it needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC / fetch front end: owns the PC, issues one outstanding fetch at a time to
// memctrl, queues returned instructions and presents {pc, inst} to decode.
module pc_fetch_unit
  import pc_fetch_unit_pkg::*;
#(
  parameter int unsigned        ADDR_W     = FETCH_ADDR_W,
  parameter int unsigned        INST_W     = FETCH_INST_W,
  parameter int unsigned        INST_BYTES = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC   = '0,
  parameter int unsigned        QDEPTH     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic              if_valid_o,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  input  logic              if_ready_i
);

  localparam int unsigned CNT_W = $clog2(QDEPTH) + 1;
  localparam int unsigned OCC_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] fetch_addr_q;
  logic              inflight_q;

  logic [ADDR_W-1:0] redirect_target;
  logic              pop;
  logic              push;
  logic              q_full;
  logic              q_empty;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W+INST_W-1:0] q_head;
  logic [OCC_W-1:0]  occ_now;
  logic [OCC_W-1:0]  occ_after_push;
  logic              space_now;
  logic              space_after_push;

  assign redirect_target = redirect_pc_i & ALIGN_MASK;
  assign mem_addr_o      = pc_q;
  assign if_valid_o      = !q_empty;
  assign {if_pc_o, if_inst_o} = q_head;

  // Decode's pop is ignored on a redirect because the queue flushes that cycle.
  assign pop  = if_valid_o && if_ready_i;
  assign push = (state_q == FETCH_WAIT) && mem_rvalid_i && !redirect_i && (!q_full || pop);

  // The in-flight fetch holds a reserved slot so a returning push never meets a full queue.
  assign occ_now          = {1'b0, q_count} + OCC_W'(inflight_q);
  assign occ_after_push   = {1'b0, q_count} + OCC_W'(1) - OCC_W'(pop);
  assign space_now        = occ_now < OCC_W'(QDEPTH);
  assign space_after_push = occ_after_push < OCC_W'(QDEPTH);

  fetch_queue #(
    .WIDTH (ADDR_W + INST_W),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({fetch_addr_q, mem_rdata_i}),
    .pop       (pop),
    .flush     (redirect_i),
    .head_data (q_head),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  // Fetch FSM: PC, request line, in-flight flag and the address latched at grant.
  // A redirect overrides every other transition; a fetch already granted is
  // parked in DROP so its response is swallowed rather than queued.
  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= RESET_PC;
      fetch_addr_q <= RESET_PC;
      inflight_q   <= 1'b0;
      mem_req_o    <= 1'b0;
    end else begin
      case (state_q)
        FETCH_IDLE: begin
          if (redirect_i) begin
            pc_q      <= redirect_target;
            state_q   <= FETCH_REQ;
            mem_req_o <= 1'b1;
          end else if (space_now) begin
            state_q   <= FETCH_REQ;
            mem_req_o <= 1'b1;
          end
        end
        FETCH_REQ: begin
          if (redirect_i) begin
            pc_q      <= redirect_target;
            mem_req_o <= 1'b0;
            if (mem_gnt_i) begin
              inflight_q <= 1'b1;
              state_q    <= FETCH_DROP;
            end else begin
              state_q <= FETCH_IDLE;
            end
          end else if (mem_gnt_i) begin
            fetch_addr_q <= pc_q;
            pc_q         <= pc_q + ADDR_W'(INST_BYTES);
            inflight_q   <= 1'b1;
            mem_req_o    <= 1'b0;
            state_q      <= FETCH_WAIT;
          end
        end
        FETCH_WAIT: begin
          if (redirect_i) pc_q <= redirect_target;
          if (mem_rvalid_i) begin
            inflight_q <= 1'b0;
            if (redirect_i || space_after_push) begin
              state_q   <= FETCH_REQ;
              mem_req_o <= 1'b1;
            end else begin
              state_q <= FETCH_IDLE;
            end
          end else if (redirect_i) begin
            state_q <= FETCH_DROP;
          end
        end
        FETCH_DROP: begin
          if (redirect_i) pc_q <= redirect_target;
          if (mem_rvalid_i) begin
            inflight_q <= 1'b0;
            state_q    <= FETCH_REQ;
            mem_req_o  <= 1'b1;
          end
        end
        default: begin
          state_q   <= FETCH_IDLE;
          mem_req_o <= 1'b0;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  // A response arriving before the first post-reset grant belongs to a fetch
  // cut off by reset and is legitimately ignored; after that, rvalid must only
  // arrive while a fetch is outstanding.
  logic seen_gnt_q;

  // Track whether any grant has happened since reset.
  always_ff @(posedge clk) begin
    if (rst == RSTN_ENABLE)           seen_gnt_q <= 1'b0;
    else if (mem_req_o && mem_gnt_i) seen_gnt_q <= 1'b1;
  end

  rvalid_only_when_outstanding: assert property (
    @(posedge clk) disable iff (rst == RSTN_ENABLE)
      (mem_rvalid_i && seen_gnt_q) |-> (state_q inside {FETCH_WAIT, FETCH_DROP})
  ) else $error("mem_rvalid_i with no fetch outstanding");
`endif

endmodule
